fft_frame_ctrl: RTL and testbench

Frame controller placed between the serial I/Q sample stream and the 16-point FFT core. It gates sample capture with a start/stop command and assembles 16 accepted samples into one parallel frame. The frame is held in an output register with a valid/ready handshake toward the FFT, so a stalled FFT never sees a torn frame. It also counts delivered and dropped frames, and can stop automatically after a programmed number of frames.

---
 rtl/fft_pkg.sv | 12 +
 rtl/frame_shift_reg.sv | 40 ++++
 rtl/fft_frame_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT front-end blocks.
package fft_pkg;
    localparam int FFT_N    = 16;
    localparam int SAMPLE_W = 9;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } frame_state_e;
endpackage

// File: rtl/frame_shift_reg.sv
// Enabled I/Q shift register; new samples enter at the top, index 0 is the oldest.
module frame_shift_reg
    import fft_pkg::*;
#(
    parameter int P_SIZE = FFT_N,
    parameter int DW     = SAMPLE_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_din_i,
    input  logic signed [DW-1:0] i_din_q,
    output logic signed [DW-1:0] o_q_i [P_SIZE],
    output logic signed [DW-1:0] o_q_q [P_SIZE]
);

    logic signed [DW-1:0] r_i [P_SIZE];
    logic signed [DW-1:0] r_q [P_SIZE];

    // Shift toward index 0 on each enabled cycle, newest sample lands at P_SIZE-1
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < P_SIZE; k++) begin
                r_i[k] <= '0;
                r_q[k] <= '0;
            end
        end else if (i_en) begin
            for (int k = 0; k < P_SIZE-1; k++) begin
                r_i[k] <= r_i[k+1];
                r_q[k] <= r_q[k+1];
            end
            r_i[P_SIZE-1] <= i_din_i;
            r_q[P_SIZE-1] <= i_din_q;
        end
    end

    assign o_q_i = r_i;
    assign o_q_q = r_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame controller: gates capture, assembles P_SIZE-sample frames, holds them for the FFT.
//
// state | meaning
// IDLE  | capture off; hold register may still present a pending frame
// FILL  | accepting samples; frames load into the hold register or are dropped
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int P_SIZE = FFT_N,
    parameter int DW     = SAMPLE_W,
    parameter int CW     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [CW-1:0]        i_num_frames,
    input  logic                 i_in_valid,
    input  logic signed [DW-1:0] i_din_i,
    input  logic signed [DW-1:0] i_din_q,
    input  logic                 i_fft_ready,
    output logic signed [DW-1:0] o_dout_i [P_SIZE],
    output logic signed [DW-1:0] o_dout_q [P_SIZE],
    output logic                 o_dout_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic [CW-1:0]        o_frame_cnt,
    output logic [CW-1:0]        o_drop_cnt
);

    localparam int IW = $clog2(P_SIZE);

    frame_state_e          r_state;
    frame_state_e          w_next_state;
    logic [IW-1:0]         r_idx;
    logic [CW-1:0]         r_num_frames;
    logic [CW-1:0]         r_frame_cnt;
    logic [CW-1:0]         r_drop_cnt;
    logic                  r_overflow;
    logic                  r_done;
    logic                  r_dout_valid;
    logic signed [DW-1:0]  r_dout_i [P_SIZE];
    logic signed [DW-1:0]  r_dout_q [P_SIZE];

    logic                  w_busy;
    logic                  w_start;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_load;
    logic                  w_drop;
    logic                  w_auto_stop;
    logic [CW-1:0]         w_frame_cnt_inc;
    logic signed [DW-1:0]  w_sr_i [P_SIZE];
    logic signed [DW-1:0]  w_sr_q [P_SIZE];
    logic signed [DW-1:0]  w_frame_i [P_SIZE];
    logic signed [DW-1:0]  w_frame_q [P_SIZE];

    frame_shift_reg #(
        .P_SIZE (P_SIZE),
        .DW     (DW)
    ) u_shift (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_accept),
        .i_din_i (i_din_i),
        .i_din_q (i_din_q),
        .o_q_i   (w_sr_i),
        .o_q_q   (w_sr_q)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic; a completing sample is still processed on a stop/auto-stop edge
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (i_start) w_next_state = FILL;
            FILL: if (i_stop || w_auto_stop) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output/strobe decode from the registered state
    always_comb begin
        w_busy          = (r_state == FILL);
        w_start         = (r_state == IDLE) && i_start;
        w_accept        = w_busy && i_in_valid;
        w_complete      = w_accept && (r_idx == IW'(P_SIZE-1));
        w_load          = w_complete && (!r_dout_valid || i_fft_ready);
        w_drop          = w_complete && r_dout_valid && !i_fft_ready;
        w_frame_cnt_inc = r_frame_cnt + CW'(1);
        w_auto_stop     = w_load && (r_num_frames != '0) && (w_frame_cnt_inc == r_num_frames);
    end

    // Completed frame is the stored samples shifted by one plus the sample arriving now
    always_comb begin
        for (int k = 0; k < P_SIZE-1; k++) begin
            w_frame_i[k] = w_sr_i[k+1];
            w_frame_q[k] = w_sr_q[k+1];
        end
        w_frame_i[P_SIZE-1] = i_din_i;
        w_frame_q[P_SIZE-1] = i_din_q;
    end

    // Sample index: cleared on start and on stop, wraps naturally at P_SIZE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx <= '0;
        end else if (w_start || (w_busy && i_stop)) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= r_idx + IW'(1);
        end
    end

    // Frame/drop counters, overflow flag and latched frame target
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_num_frames <= '0;
            r_frame_cnt  <= '0;
            r_drop_cnt   <= '0;
            r_overflow   <= 1'b0;
        end else if (w_start) begin
            r_num_frames <= i_num_frames;
            r_frame_cnt  <= '0;
            r_drop_cnt   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_load) r_frame_cnt <= w_frame_cnt_inc;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CW'(1);
            end
        end
    end

    // Done pulse lands in the cycle after the auto-stop edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_done <= 1'b0;
        else       r_done <= w_auto_stop;
    end

    // Hold register with valid/ready handshake; a load on a consume edge keeps valid high
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dout_valid <= 1'b0;
            for (int k = 0; k < P_SIZE; k++) begin
                r_dout_i[k] <= '0;
                r_dout_q[k] <= '0;
            end
        end else if (w_load) begin
            r_dout_valid <= 1'b1;
            r_dout_i     <= w_frame_i;
            r_dout_q     <= w_frame_q;
        end else if (r_dout_valid && i_fft_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign o_dout_i     = r_dout_i;
    assign o_dout_q     = r_dout_q;
    assign o_dout_valid = r_dout_valid;
    assign o_busy       = w_busy;
    assign o_done       = r_done;
    assign o_overflow   = r_overflow;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with hand-computed expected frames.
module tb_fft_frame_ctrl;

    localparam int P  = 16;
    localparam int DW = 9;
    localparam int CW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 stop = 1'b0;
    logic [CW-1:0]        num_frames = '0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] din_i = '0;
    logic signed [DW-1:0] din_q = '0;
    logic                 fft_ready = 1'b0;
    logic signed [DW-1:0] dout_i [P];
    logic signed [DW-1:0] dout_q [P];
    logic                 dout_valid;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic [CW-1:0]        frame_cnt;
    logic [CW-1:0]        drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fft_frame_ctrl #(.P_SIZE(P), .DW(DW), .CW(CW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_stop       (stop),
        .i_num_frames (num_frames),
        .i_in_valid   (in_valid),
        .i_din_i      (din_i),
        .i_din_q      (din_q),
        .i_fft_ready  (fft_ready),
        .o_dout_i     (dout_i),
        .o_dout_q     (dout_q),
        .o_dout_valid (dout_valid),
        .o_busy       (busy),
        .o_done       (done),
        .o_overflow   (overflow),
        .o_frame_cnt  (frame_cnt),
        .o_drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int vi, input int vq);
        in_valid = 1'b1;
        din_i    = DW'(vi);
        din_q    = DW'(vq);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_start(input int nf);
        num_frames = CW'(nf);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        tick();
        tick();
        bad = 0;
        for (int k = 0; k < P; k++) if (dout_i[k] !== '0 || dout_q[k] !== '0) bad++;
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL reset_data nonzero_words=%0d want 0", bad); end
        n_checks++; if ({dout_valid, busy, done, overflow} !== 4'b0000) begin n_errors++; $display("FAIL reset_flags got %b want 0000", {dout_valid, busy, done, overflow}); end
        n_checks++; if (frame_cnt !== '0 || drop_cnt !== '0) begin n_errors++; $display("FAIL reset_cnts got %0d/%0d want 0/0", frame_cnt, drop_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        int bad;
        fft_ready = 1'b1;
        do_start(1);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy got %b want 1", busy); end
        for (int k = 0; k < P-1; k++) send(k, -k);
        n_checks++; if (dout_valid !== 1'b0) begin n_errors++; $display("FAIL single_early_valid got %b want 0", dout_valid); end
        send(P-1, -(P-1));
        n_checks++; if (dout_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid got %b want 1", dout_valid); end
        bad = 0;
        for (int k = 0; k < P; k++) if (dout_i[k] !== DW'(k) || dout_q[k] !== DW'(-k)) bad++;
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL single_data bad_words=%0d want 0", bad); end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL single_done done=%b busy=%b want 1/0", done, busy); end
        n_checks++; if (frame_cnt !== CW'(1)) begin n_errors++; $display("FAIL single_frame_cnt got %0d want 1", frame_cnt); end
        tick();
        n_checks++; if (done !== 1'b0 || dout_valid !== 1'b0) begin n_errors++; $display("FAIL single_after done=%b valid=%b want 0/0", done, dout_valid); end
    endtask

    task automatic test_gapped();
        int bad;
        fft_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(200 + k, 7);
        do_start(1);
        for (int k = 0; k < P; k++) begin
            send(k, -k);
            repeat ($urandom_range(0, 2)) tick();
        end
        bad = 0;
        for (int k = 0; k < P; k++) if (dout_i[k] !== DW'(k) || dout_q[k] !== DW'(-k)) bad++;
        n_checks++; if (bad !== 0 || dout_valid !== 1'b1) begin n_errors++; $display("FAIL gapped_data bad_words=%0d valid=%b want 0/1", bad, dout_valid); end
        n_checks++; if (busy !== 1'b0 || frame_cnt !== CW'(1)) begin n_errors++; $display("FAIL gapped_end busy=%b cnt=%0d want 0/1", busy, frame_cnt); end
        fft_ready = 1'b1;
        tick();
        fft_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        fft_ready = 1'b0;
        do_start(0);
        for (int k = 0; k < P; k++) send(k, -k);
        n_checks++; if (dout_valid !== 1'b1 || dout_i[15] !== DW'(15)) begin n_errors++; $display("FAIL bp_first valid=%b d15=%0d want 1/15", dout_valid, dout_i[15]); end
        for (int k = P; k < 40; k++) send(k, -k);
        n_checks++; if (dout_i[0] !== DW'(0) || dout_i[15] !== DW'(15) || dout_q[7] !== DW'(-7)) begin n_errors++; $display("FAIL bp_stable d0=%0d d15=%0d q7=%0d want 0/15/-7", dout_i[0], dout_i[15], dout_q[7]); end
        n_checks++; if (overflow !== 1'b1 || drop_cnt !== CW'(1) || frame_cnt !== CW'(1)) begin n_errors++; $display("FAIL bp_drop ovf=%b drop=%0d frames=%0d want 1/1/1", overflow, drop_cnt, frame_cnt); end
        fft_ready = 1'b1;
        for (int k = 40; k < 48; k++) send(k, -k);
        n_checks++; if (dout_valid !== 1'b1 || dout_i[0] !== DW'(32) || dout_i[15] !== DW'(47)) begin n_errors++; $display("FAIL bp_resume valid=%b d0=%0d d15=%0d want 1/32/47", dout_valid, dout_i[0], dout_i[15]); end
        n_checks++; if (frame_cnt !== CW'(2) || drop_cnt !== CW'(1) || busy !== 1'b1) begin n_errors++; $display("FAIL bp_cnts frames=%0d drop=%0d busy=%b want 2/1/1", frame_cnt, drop_cnt, busy); end
        fft_ready = 1'b0;
        do_stop();
    endtask

    task automatic test_back_to_back();
        fft_ready = 1'b1;
        tick();
        n_checks++; if (dout_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got %b want 0", dout_valid); end
        fft_ready = 1'b0;
        do_start(0);
        n_checks++; if (overflow !== 1'b0 || drop_cnt !== '0 || frame_cnt !== '0) begin n_errors++; $display("FAIL b2b_clear ovf=%b drop=%0d frames=%0d want 0/0/0", overflow, drop_cnt, frame_cnt); end
        for (int k = 0; k < P; k++) send(100 + k, k);
        for (int k = P; k < 2*P-1; k++) send(100 + k, k);
        fft_ready = 1'b1;
        send(100 + 2*P - 1, 2*P - 1);
        n_checks++; if (dout_valid !== 1'b1 || dout_i[0] !== DW'(116) || dout_i[15] !== DW'(131) || dout_q[15] !== DW'(31)) begin n_errors++; $display("FAIL b2b_data valid=%b d0=%0d d15=%0d q15=%0d want 1/116/131/31", dout_valid, dout_i[0], dout_i[15], dout_q[15]); end
        n_checks++; if (drop_cnt !== '0 || overflow !== 1'b0 || frame_cnt !== CW'(2)) begin n_errors++; $display("FAIL b2b_cnts drop=%0d ovf=%b frames=%0d want 0/0/2", drop_cnt, overflow, frame_cnt); end
        tick();
        n_checks++; if (dout_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_consume got %b want 0", dout_valid); end
        do_stop();
    endtask

    task automatic test_stop();
        fft_ready = 1'b1;
        do_start(0);
        for (int k = 0; k < 7; k++) send(90 + k, 0);
        do_stop();
        n_checks++; if (busy !== 1'b0 || dout_valid !== 1'b0 || frame_cnt !== '0) begin n_errors++; $display("FAIL stop_abort busy=%b valid=%b frames=%0d want 0/0/0", busy, dout_valid, frame_cnt); end
        do_start(0);
        for (int k = 0; k < P; k++) send(20 + k, -k);
        n_checks++; if (dout_valid !== 1'b1 || dout_i[0] !== DW'(20) || dout_i[15] !== DW'(35)) begin n_errors++; $display("FAIL stop_clean valid=%b d0=%0d d15=%0d want 1/20/35", dout_valid, dout_i[0], dout_i[15]); end
        for (int k = 0; k < P-1; k++) send(40 + k, k);
        stop = 1'b1;
        send(55, 15);
        stop = 1'b0;
        n_checks++; if (dout_valid !== 1'b1 || dout_i[0] !== DW'(40) || dout_i[15] !== DW'(55)) begin n_errors++; $display("FAIL stop_coincident valid=%b d0=%0d d15=%0d want 1/40/55", dout_valid, dout_i[0], dout_i[15]); end
        n_checks++; if (busy !== 1'b0 || frame_cnt !== CW'(2) || done !== 1'b0) begin n_errors++; $display("FAIL stop_state busy=%b frames=%0d done=%b want 0/2/0", busy, frame_cnt, done); end
        tick();
        fft_ready = 1'b0;
    endtask

    task automatic test_autostop_drops();
        fft_ready = 1'b0;
        do_start(2);
        for (int k = 0; k < 2*P; k++) send(k, 0);
        n_checks++; if (busy !== 1'b1 || drop_cnt !== CW'(1) || frame_cnt !== CW'(1) || done !== 1'b0) begin n_errors++; $display("FAIL auto_drop busy=%b drop=%0d frames=%0d done=%b want 1/1/1/0", busy, drop_cnt, frame_cnt, done); end
        fft_ready = 1'b1;
        for (int k = 2*P; k < 3*P; k++) send(k, 0);
        n_checks++; if (busy !== 1'b0 || done !== 1'b1 || frame_cnt !== CW'(2) || dout_i[0] !== DW'(32)) begin n_errors++; $display("FAIL auto_stop busy=%b done=%b frames=%0d d0=%0d want 0/1/2/32", busy, done, frame_cnt, dout_i[0]); end
        tick();
        fft_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        fft_ready = 1'b0;
        do_start(0);
        for (int k = 0; k < P; k++) send(60 + k, k);
        for (int k = 0; k < 9; k++) send(k, k);
        n_checks++; if (dout_valid !== 1'b1 || busy !== 1'b1) begin n_errors++; $display("FAIL rstmid_pre valid=%b busy=%b want 1/1", dout_valid, busy); end
        rst = 1'b1;
        #1;
        bad = 0;
        for (int k = 0; k < P; k++) if (dout_i[k] !== '0 || dout_q[k] !== '0) bad++;
        n_checks++; if (bad !== 0 || dout_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== '0 || overflow !== 1'b0) begin n_errors++; $display("FAIL rstmid_async bad_words=%0d valid=%b busy=%b frames=%0d want 0/0/0/0", bad, dout_valid, busy, frame_cnt); end
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < P; k++) send(k, k);
        n_checks++; if (busy !== 1'b0 || dout_valid !== 1'b0 || frame_cnt !== '0) begin n_errors++; $display("FAIL rstmid_idle busy=%b valid=%b frames=%0d want 0/0/0", busy, dout_valid, frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gapped();
        test_backpressure();
        test_back_to_back();
        test_stop();
        test_autostop_drops();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
